key_debounce_repeat: RTL and testbench
======================================

// Module: key_debounce_repeat
// PURPOSE
//  Front-end for the board push-buttons: synchronises the active-low KEY inputs and debounces them.
//  Emits one-clock press pulses in the same bit order as the button bus feeding CONTROL:
//    {sel[2:0], dec, clr, que, ready}.
//  Keys enabled in REPEAT_MASK (the sel keys) auto-repeat while held, so a held digit-select key
//  keeps stepping.
// PARAMETERS
//  WIDTH         7        number of keys
//  SAMPLE_DIV    500000   clocks per sample tick (10 ms at 50 MHz); must be >= 2
//  DEBOUNCE_CNT  3        consecutive equal samples needed to change the debounced level; >= 1
//  REPEAT_MASK   7'h70    1 = key auto-repeats (bits 6:4 = sel)
//  REPEAT_DELAY  50       ticks from accepted press to first repeat pulse; >= 1
//  REPEAT_RATE   10       ticks between later repeat pulses; >= 1
// PORTS
//  CLK    in   1      system clock
//  RST    in   1      asynchronous reset, active-low
//  nBIN   in   WIDTH  raw keys, 0 = pressed, asynchronous to CLK
//  BOUT   out  WIDTH  one-CLK press / repeat pulses, active-high
//  LEVEL  out  WIDTH  debounced level, 1 = held
//  TICK   out  1      one-CLK sample strobe (bench visibility)
// BEHAVIOUR
//  Reset (RST=0, async)
//   - All flops clear: BOUT=0, LEVEL=0, TICK=0; divider, debounce and repeat counters = 0.
//   - Synchroniser flops reset to 0, i.e. "pressed" after inversion, for now. They are corrected
//     after 2 clocks, so no pulse can result.
//   - Reset mid-press: pending or ongoing repeat is dropped.
//   - A key still held after reset release is treated as a new press.
//  Input path
//   - nBIN -> 2-FF synchroniser -> inverted to raw pressed = 1. Latency 2 CLK.
//  Tick
//   - Divider counts 0..SAMPLE_DIV-1, wraps to 0.
//   - TICK=1 for exactly one CLK when the count equals SAMPLE_DIV-1.
//   - First TICK comes SAMPLE_DIV clocks after reset release.
//  Debounce, per key, evaluated only on TICK
//   - raw == LEVEL: count := 0.
//   - raw != LEVEL and count+1 == DEBOUNCE_CNT: LEVEL := raw, count := 0.
//   - Otherwise: count += 1.
//   - Glitches shorter than DEBOUNCE_CNT ticks never change LEVEL.
//  Per-key state machine (repeat logic only in REPEAT_MASK bits; others use IDLE/HELD only)
//   - IDLE   : on the TICK where LEVEL rises -> BOUT=1 next CLK; go to HELD, rcnt := 0.
//   - HELD   : each TICK rcnt += 1.
//              rcnt+1 == REPEAT_DELAY -> BOUT pulse, go to REPEAT, rcnt := 0.
//              LEVEL falls -> IDLE, no pulse.
//   - REPEAT : each TICK rcnt += 1.
//              rcnt+1 == REPEAT_RATE -> BOUT pulse, rcnt := 0.
//              LEVEL falls -> IDLE.
//   - Release-then-press inside one tick is impossible (sampling); no pulse on release.
//  Outputs and widths
//   - BOUT registered, high exactly 1 CLK, in the CLK after the qualifying TICK.
//   - Keys are fully independent; simultaneous presses give simultaneous pulses in the same cycle.
//   - Counter widths: $clog2 of their maximum, saturation never reached (all wrap by design).
// TESTING  (bench params: SAMPLE_DIV=4, DEBOUNCE_CNT=3, REPEAT_DELAY=5, REPEAT_RATE=2)
//  1 Reset, nBIN=7'h7F for 100 clk -> BOUT, LEVEL stay 0; TICK every 4 clk.
//  2 nBIN[0]=0 held 40 clk -> LEVEL[0]=1 after 3rd tick; one BOUT[0] pulse; no repeat (bit 0 not in mask).
//  3 nBIN[0] low for 1 tick then high, repeated 5x -> LEVEL[0] never 1, BOUT[0] never 1.
//  4 nBIN[6]=0 held 60 ticks -> pulse at press, 2nd pulse 5 ticks later, then every 2 ticks;
//    total = 1 + 1 + floor((60-3-5)/2) +/-1 per timing. Check exact spacing, not count.
//  5 nBIN[4] and nBIN[1] pressed same clk -> BOUT=7'h12 in the same cycle.
//  6 Hold nBIN[5] into repeat, pulse RST low 1 clk -> all outputs 0 at once;
//    after 3 ticks one fresh press pulse, repeat restarts from REPEAT_DELAY.

Source files
------------

// File: rtl/key_debounce_repeat.sv
// Push-button front end: 2-FF synchroniser, tick-sampled debounce and
// per-key press / auto-repeat pulse generation.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | key released, waiting for the debounced level to rise
// HELD   | press pulse sent, counting ticks towards the first repeat
// REPEAT | auto-repeating, one pulse every REPEAT_RATE ticks
module key_debounce_repeat #(
   parameter int               WIDTH        = 7,
   parameter int               SAMPLE_DIV   = 500000,
   parameter int               DEBOUNCE_CNT = 3,
   parameter logic [WIDTH-1:0] REPEAT_MASK  = 7'h70,
   parameter int               REPEAT_DELAY = 50,
   parameter int               REPEAT_RATE  = 10
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] nBIN,
   output logic [WIDTH-1:0] BOUT,
   output logic [WIDTH-1:0] LEVEL,
   output logic             TICK
);

   localparam int DW   = $clog2(SAMPLE_DIV);
   localparam int CW   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

   localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);
   localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, REPEAT = 2'd2} key_state_t;

   logic [WIDTH-1:0] sync1, sync2;
   logic [WIDTH-1:0] raw;
   logic [DW-1:0]    div;

   // Two-stage synchroniser; reset value reads as "pressed" for two clocks,
   // which is harmless because no tick can occur that early.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= nBIN;
         sync2 <= sync1;
      end
   end

   assign raw = ~sync2;

   // Sample-tick divider, wraps on the terminal count.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) div <= '0;
      else if (TICK) div <= '0;
      else div <= div + 1'b1;
   end

   assign TICK = (div == DIV_LAST);

   for (genvar i = 0; i < WIDTH; i++) begin : g_key
      localparam bit REP = REPEAT_MASK[i];

      logic          level, level_nxt;
      logic [CW-1:0] dcnt, dcnt_nxt;
      logic          rise, fall;
      key_state_t    state, state_nxt;
      logic [RW-1:0] rcnt, rcnt_nxt;
      logic          pulse, bout;

      // Debounce: LEVEL follows raw only after DEBOUNCE_CNT disagreeing ticks.
      always_comb begin
         level_nxt = level;
         dcnt_nxt  = dcnt;
         rise      = 1'b0;
         fall      = 1'b0;
         if (TICK) begin
            if (raw[i] == level) begin
               dcnt_nxt = '0;
            end else if (dcnt == DB_LAST) begin
               level_nxt = raw[i];
               dcnt_nxt  = '0;
               rise      = raw[i];
               fall      = ~raw[i];
            end else begin
               dcnt_nxt = dcnt + 1'b1;
            end
         end
      end

      // State register with debounce level, counters and registered pulse.
      always_ff @(posedge CLK or negedge RST) begin
         if (!RST) begin
            level <= 1'b0;
            dcnt  <= '0;
            state <= IDLE;
            rcnt  <= '0;
            bout  <= 1'b0;
         end else begin
            level <= level_nxt;
            dcnt  <= dcnt_nxt;
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            bout  <= pulse;
         end
      end

      // Next-state logic; a falling level always wins over a repeat.
      always_comb begin
         state_nxt = state;
         rcnt_nxt  = rcnt;
         case (state)
            IDLE: begin
               if (rise) begin
                  state_nxt = HELD;
                  rcnt_nxt  = '0;
               end
            end
            HELD: begin
               if (fall) begin
                  state_nxt = IDLE;
               end else if (TICK && REP) begin
                  if (rcnt == DLY_LAST) begin
                     state_nxt = REPEAT;
                     rcnt_nxt  = '0;
                  end else begin
                     rcnt_nxt = rcnt + 1'b1;
                  end
               end
            end
            REPEAT: begin
               if (fall) begin
                  state_nxt = IDLE;
               end else if (TICK) begin
                  if (rcnt == RATE_LAST) rcnt_nxt = '0;
                  else rcnt_nxt = rcnt + 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               rcnt_nxt  = '0;
            end
         endcase
      end

      // Output decode: press pulse, first repeat and subsequent repeats.
      always_comb begin
         pulse = 1'b0;
         case (state)
            IDLE:    pulse = rise;
            HELD:    pulse = TICK && REP && !fall && (rcnt == DLY_LAST);
            REPEAT:  pulse = TICK && !fall && (rcnt == RATE_LAST);
            default: pulse = 1'b0;
         endcase
      end

      assign LEVEL[i] = level;
      assign BOUT[i]  = bout;
   end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed bench for key_debounce_repeat with a short tick period.
module tb_key_debounce_repeat;

   logic       CLK = 1'b0;
   logic       RST;
   logic [6:0] nBIN;
   logic [6:0] BOUT, LEVEL;
   logic       TICK;

   int n_tests = 0;
   int n_fail  = 0;

   key_debounce_repeat #(
      .WIDTH(7), .SAMPLE_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_MASK(7'h70),
      .REPEAT_DELAY(5), .REPEAT_RATE(2)
   ) dut (
      .CLK(CLK), .RST(RST), .nBIN(nBIN), .BOUT(BOUT), .LEVEL(LEVEL), .TICK(TICK)
   );

   always #5 CLK = ~CLK;

   // monitor state
   int tick_n = 0, cyc = 0, last_tick_cyc = -1, spacing_err = 0, width_err = 0;
   int pcnt[7], plast[7], lrise[7], lfall[7], lrise_n[7];
   logic [6:0] prev_b = '0, prev_l = '0, level_seen = '0;
   int q5[$], q6[$];

   initial begin
      for (int k = 0; k < 7; k++) begin
         pcnt[k] = 0; plast[k] = -1; lrise[k] = -1; lfall[k] = -1; lrise_n[k] = 0;
      end
   end

   // Sample outputs on the falling edge, away from the active edge.
   always @(negedge CLK) begin
      cyc++;
      if (TICK) begin
         tick_n++;
         if (last_tick_cyc >= 0 && cyc - last_tick_cyc != 4) spacing_err++;
         last_tick_cyc = cyc;
      end
      for (int k = 0; k < 7; k++) begin
         if (BOUT[k]) begin
            pcnt[k]++;
            plast[k] = tick_n;
            if (k == 5) q5.push_back(tick_n);
            if (k == 6) q6.push_back(tick_n);
            if (prev_b[k]) width_err++;
         end
         if (LEVEL[k] && !prev_l[k]) begin lrise[k] = tick_n; lrise_n[k]++; end
         if (!LEVEL[k] && prev_l[k]) lfall[k] = tick_n;
      end
      level_seen = level_seen | LEVEL;
      prev_b = BOUT;
      prev_l = LEVEL;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Return #1 after the falling edge of the next TICK cycle.
   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge CLK); #1;
         n++;
      end while (!TICK && n < 16);
      if (!TICK) chk("tick_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) wait_tick();
   endtask

   int t0, r0, sp_bad, n;

   initial begin
      RST  = 1'b0;
      nBIN = 7'h7F;
      repeat (3) @(negedge CLK);
      #1;
      chk("rst_bout", 32'(BOUT), 32'd0);
      chk("rst_level", 32'(LEVEL), 32'd0);
      chk("rst_tick", 32'(TICK), 32'd0);
      RST = 1'b1;

      // 1: idle, ticks every 4 clocks
      t0 = tick_n;
      repeat (100) @(negedge CLK);
      #1;
      chk("idle_ticks", 32'(tick_n - t0), 32'd25);
      chk("idle_tick_spacing", 32'(spacing_err), 32'd0);
      chk("idle_pulses", 32'(pcnt[0]+pcnt[1]+pcnt[2]+pcnt[3]+pcnt[4]+pcnt[5]+pcnt[6]), 32'd0);
      chk("idle_level", 32'(level_seen), 32'd0);

      // 2: key 0 held 10 ticks, single pulse, then release
      wait_tick();
      t0 = tick_n;
      nBIN[0] = 1'b0;
      wait_ticks(10);
      chk("k0_level_rise_tick", 32'(lrise[0] - t0), 32'd3);
      chk("k0_pulse_tick", 32'(plast[0] - t0), 32'd3);
      chk("k0_pulse_count", 32'(pcnt[0]), 32'd1);
      t0 = tick_n;
      nBIN[0] = 1'b1;
      wait_ticks(5);
      chk("k0_level_fall_tick", 32'(lfall[0] - t0), 32'd3);
      chk("k0_no_release_pulse", 32'(pcnt[0]), 32'd1);

      // 3: one-tick glitches, then a two-tick glitch
      for (int i = 0; i < 5; i++) begin
         wait_tick(); nBIN[0] = 1'b0;
         wait_tick(); nBIN[0] = 1'b1;
         wait_ticks(3);
      end
      wait_tick(); nBIN[0] = 1'b0;
      wait_ticks(2); nBIN[0] = 1'b1;
      wait_ticks(4);
      chk("glitch_level_rises", 32'(lrise_n[0]), 32'd1);
      chk("glitch_pulses", 32'(pcnt[0]), 32'd1);

      // 4: key 6 held 60 ticks, auto-repeat spacing
      wait_tick();
      t0 = tick_n;
      nBIN[6] = 1'b0;
      wait_ticks(60);
      nBIN[6] = 1'b1;
      wait_ticks(6);
      chk("k6_pulse_count", 32'(q6.size()), 32'd29);
      chk("k6_first_pulse", 32'(q6[0] - t0), 32'd3);
      chk("k6_repeat_delay", 32'(q6[1] - q6[0]), 32'd5);
      sp_bad = 0;
      for (int i = 2; i < q6.size(); i++) if (q6[i] - q6[i-1] != 2) sp_bad++;
      chk("k6_repeat_rate", 32'(sp_bad), 32'd0);
      chk("k6_level_fall_tick", 32'(lfall[6] - t0), 32'd63);

      // 5: keys 4 and 1 pressed together
      wait_tick();
      t0 = tick_n;
      nBIN[4] = 1'b0;
      nBIN[1] = 1'b0;
      n = 0;
      do begin @(negedge CLK); #1; n++; end while (BOUT == 7'h00 && n < 40);
      chk("dual_bout", 32'(BOUT), 32'h12);
      chk("dual_tick", 32'(tick_n - t0), 32'd3);
      wait_tick();
      nBIN[4] = 1'b1;
      nBIN[1] = 1'b1;
      wait_ticks(6);
      chk("dual_k4_count", 32'(pcnt[4]), 32'd1);
      chk("dual_k1_count", 32'(pcnt[1]), 32'd1);

      // 6: key 5 into repeat, reset mid-press
      wait_tick();
      t0 = tick_n;
      nBIN[5] = 1'b0;
      n = 0;
      do begin @(negedge CLK); #1; n++; end while (pcnt[5] < 3 && n < 200);
      chk("k5_third_pulse", 32'(plast[5] - t0), 32'd10);
      RST = 1'b0;
      #1;
      chk("async_rst_bout", 32'(BOUT), 32'd0);
      chk("async_rst_level", 32'(LEVEL), 32'd0);
      chk("async_rst_tick", 32'(TICK), 32'd0);
      @(negedge CLK); #1;
      RST = 1'b1;
      r0 = tick_n;
      n = 0;
      do begin @(negedge CLK); #1; n++; end while (pcnt[5] < 6 && n < 200);
      chk("k5_pulse_total", 32'(q5.size()), 32'd6);
      chk("k5_fresh_press", 32'(q5[3] - r0), 32'd3);
      chk("k5_level_rise", 32'(lrise[5] - r0), 32'd3);
      chk("k5_delay_after_rst", 32'(q5[4] - q5[3]), 32'd5);
      chk("k5_rate_after_rst", 32'(q5[5] - q5[4]), 32'd2);
      nBIN[5] = 1'b1;
      wait_ticks(5);

      chk("other_keys_quiet", 32'(pcnt[2] + pcnt[3]), 32'd0);
      chk("pulse_width", 32'(width_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
